// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl : 68000 interrupt controller for the m68kfpga peripheral bus.
//
// Seven peripheral interrupt lines are hard-wired one per 68k priority level
// (irq_in[i-1] = level i). Each line is latched into a pending bit, which is
// either edge-captured or level-following depending on MODE. Pending bits are
// masked, priority-encoded and driven registered onto the CPU IPL pins. The
// controller answers the CPU interrupt-acknowledge cycle with a vector number
// and clears the serviced edge source.
//
// Register map (word address addr[7:1], low byte only, bit i = level i):
//   0 PENDING  read pending, write-1-to-clear edge-mode bits
//   1 MASK     R/W, 1 = enabled
//   2 MODE     R/W, 1 = edge, 0 = level
//   3 VBASE    R/W, bits 7:3 stored
//   5 AVEC     R/W, 1 = autovector this level (only with IRQ_AUTOVEC_EN)
//   others     read 0, writes ignored, still acknowledged
//
// Ports:
//   clk, reset_n   system clock, synchronous active-low reset
//   irq_in[6:0]    interrupt requests, active high, synchronous to clk
//   data_write     bus write data (only [7:1] used)
//   data_read      registered bus read data / IACK vector
//   addr[7:0]      byte address within the block
//   uds, lds       upper / lower data strobes, address-qualified
//   rw             1 = read, 0 = write
//   iack           interrupt-acknowledge cycle (FC = 7)
//   iack_level     level being acknowledged (CPU A3..A1)
//   ipl_n[2:0]     active-low encoded priority to the CPU
//   ack            bus cycle acknowledge (DTACK-style)
//   avec_n         autovector request, active low (IRQ_AUTOVEC_EN only)
//
// Build option: define IRQ_AUTOVEC_EN to add the AVEC register and the
// avec_n output. Without it every acknowledge is vectored.
// -----------------------------------------------------------------------------
module irq_ctrl #(
   parameter logic [7:0] VEC_BASE_RST = 8'h40,
   parameter logic [7:0] SPURIOUS_VEC = 8'h18
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  irq_in,
   input  logic [15:0] data_write,
   output logic [15:0] data_read,
   input  logic [7:0]  addr,
   input  logic        uds,
   input  logic        lds,
   input  logic        rw,
   input  logic        iack,
   input  logic [2:0]  iack_level,
   output logic [2:0]  ipl_n,
   output logic        ack
`ifdef IRQ_AUTOVEC_EN
   ,
   output logic        avec_n
`endif
);

   // Highest set level (1..7) of a level vector, 0 when none is set.
   function automatic logic [2:0] prio_enc(input logic [6:0] lv);
      prio_enc = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (lv[i]) prio_enc = 3'(i + 1);
      end
   endfunction

   // One-hot level vector for a 68k level number; level 0 selects nothing.
   function automatic logic [6:0] level_sel(input logic [2:0] lvl);
      level_sel = 7'd0;
      if (lvl != 3'd0) level_sel[lvl - 3'd1] = 1'b1;
   endfunction

   // ---------------------------------------------------------------- state
   logic [6:0] pending;
   logic [6:0] mask;
   logic [6:0] mode;
   logic [6:0] irq_r;
   logic [7:3] vbase;
   logic       iack_done;
`ifdef IRQ_AUTOVEC_EN
   logic [6:0] avec;
`endif

   // ---------------------------------------------------------------- decode
   logic       strobe;
   logic       bus_cyc;
   logic       iack_cyc;
   logic       wr_lo;
   logic [6:0] word;
   logic [6:0] active;
   logic [6:0] rise;
   logic [6:0] lvl_sel;
   logic [6:0] iack_clr;
   logic [6:0] w1c;
   logic [6:0] edge_next;
   logic [6:0] pending_next;
   logic       lvl_active;
   logic [7:0] vector;
   logic [7:0] rd_lo;
   logic       avec_hit;
   logic       ack_next;
   logic       unused_ok;

   assign strobe   = uds | lds;
   // A normal register access is any strobed cycle that is not an IACK.
   assign bus_cyc  = strobe & ~iack;
   // An IACK with rw=0 is not a valid acknowledge and is left unanswered.
   assign iack_cyc = strobe & iack & rw;
   assign wr_lo    = bus_cyc & ~rw & lds;
   assign word     = addr[7:1];

   assign active   = pending & mask;
   assign rise     = irq_in & ~irq_r;
   assign lvl_sel  = level_sel(iack_level);

   // The acknowledged source is cleared only on the first strobed cycle;
   // iack_done holds off further clears so a fresh edge arriving while the
   // CPU keeps its strobes asserted is not lost.
   assign iack_clr = (iack_cyc && !iack_done) ? lvl_sel : 7'd0;
   assign w1c      = (wr_lo && word == 7'd0) ? data_write[7:1] : 7'd0;

   // Edge capture: a new rising edge wins over any clear in the same cycle.
   assign edge_next    = (pending & ~(w1c | iack_clr)) | rise;
   assign pending_next = (mode & edge_next) | (~mode & irq_in);

   assign lvl_active = |(active & lvl_sel);
   assign vector     = lvl_active ? {vbase, iack_level} : SPURIOUS_VEC;

`ifdef IRQ_AUTOVEC_EN
   assign avec_hit = iack_cyc & |(avec & lvl_sel);
`else
   assign avec_hit = 1'b0;
`endif

   // Autovectored acknowledges are answered on avec_n instead of ack.
   assign ack_next = (bus_cyc | iack_cyc) & ~avec_hit;

   always_comb begin
      rd_lo = 8'h00;
      case (word)
         7'd0:    rd_lo = {pending, 1'b0};
         7'd1:    rd_lo = {mask, 1'b0};
         7'd2:    rd_lo = {mode, 1'b0};
         7'd3:    rd_lo = {vbase, 3'b000};
`ifdef IRQ_AUTOVEC_EN
         7'd5:    rd_lo = {avec, 1'b0};
`endif
         default: rd_lo = 8'h00;
      endcase
   end

   // Upper write byte, bit 0 and the byte-address LSB carry no state.
   assign unused_ok = ^{data_write[15:8], data_write[0], addr[0]};

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending   <= 7'd0;
         mask      <= 7'd0;
         mode      <= 7'h7F;
         irq_r     <= 7'd0;
         vbase     <= VEC_BASE_RST[7:3];
         iack_done <= 1'b0;
         ipl_n     <= 3'b111;
         ack       <= 1'b0;
         data_read <= 16'h0000;
`ifdef IRQ_AUTOVEC_EN
         avec      <= 7'd0;
         avec_n    <= 1'b1;
`endif
      end else begin
         irq_r     <= irq_in;
         pending   <= pending_next;
         ipl_n     <= ~prio_enc(active);
         ack       <= ack_next;
         iack_done <= iack_cyc;
`ifdef IRQ_AUTOVEC_EN
         avec_n    <= ~avec_hit;
`endif

         if (wr_lo) begin
            case (word)
               7'd1:    mask  <= data_write[7:1];
               7'd2:    mode  <= data_write[7:1];
               7'd3:    vbase <= data_write[7:3];
`ifdef IRQ_AUTOVEC_EN
               7'd5:    avec  <= data_write[7:1];
`endif
               default: ;
            endcase
         end

         if (iack_cyc) begin
            data_read <= {8'h00, vector};
         end else if (bus_cyc && rw) begin
            if (uds) data_read[15:8] <= 8'h00;
            if (lds) data_read[7:0]  <= rd_lo;
         end
      end
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- 68000 interrupt controller. Collects up to seven peripheral interrupt lines: timer overflow, UART, SPI and others.
- Each line is hard-wired to one 68k priority level (1..7). Inputs are latched as pending, masked, priority-encoded and driven to CPU IPL pins.
- Serves the CPU interrupt-acknowledge cycle with a vector number and clears the serviced source.
- Configured over the same 16-bit peripheral bus as the other m68kfpga peripherals (timer, UART).

Parameters:
- VEC_BASE_RST, 8'h40, reset value of the vector base register.
- SPURIOUS_VEC, 8'h18, vector returned when an acknowledged level has nothing pending.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- irq_in  in  7  interrupt requests; bit i-1 = level i, active high, synchronous to clk
- data_write  in  16  bus write data
- data_read  out  16  bus read data (registered)
- addr  in  8  byte address within block; addr[7:1] selects word
- uds  in  1  upper data strobe, already qualified by address decode
- lds  in  1  lower data strobe, already qualified by address decode
- rw  in  1  1 = read, 0 = write
- iack  in  1  current cycle is interrupt acknowledge (FC=7 decode)
- iack_level  in  3  level being acknowledged (CPU A3..A1)
- ipl_n  out  3  encoded active-low priority to CPU
- ack  out  1  bus cycle acknowledge

Behaviour:
- Reset (reset_n=0 at clk edge): pending=0, mask=0 (all disabled), mode=7'h7F (all edge), vbase=VEC_BASE_RST, irq_r=0, ipl_n=3'b111, ack=0, data_read=0.
- irq_r is irq_in registered every clk. It is also cleared by reset.
- Edge-mode bit: pending[i] set at the clk edge where irq_in[i]=1 and irq_r[i]=0. It is cleared only by a W1C register write or by IACK.
- Level-mode bit: pending[i] <= irq_in[i] every clk. W1C and IACK have no effect on it.
- Edge set and clear in the same cycle: set wins.
- active = pending & mask. ipl_n <= ~(index of highest set bit of active), or 3'b111 if none. ipl_n is registered.
- Latency: irq_in rise at edge N gives pending set at edge N and ipl_n valid after edge N+1.
- Register map, word-addressed by addr[7:1]. Only the low byte is used; bits 7:1 map levels 7:1, bit 0 reads 0; upper byte reads 0, writes ignored.
  - 0: PENDING. Read returns the pending bits. A write with lds=1 is W1C for edge-mode bits.
  - 1: MASK, R/W.
  - 2: MODE, R/W; 1 = edge, 0 = level. Switching a bit to level takes effect the next clk.
  - 3: VBASE, R/W. Only bits 7:3 are stored; bits 2:0 read 0.
  - 4..127: reads 0, writes ignored, still acked.
- Bus handshake: on any clk with (uds|lds)=1, ack <= 1 the following edge; otherwise ack <= 0.
  - ack repeats each cycle while strobes stay high.
  - Reads update data_read only in the lanes whose strobe is set.
  - Register writes take effect at the strobe edge and are repeated harmlessly.
- IACK cycle: iack=1, rw=1, lds=1. Register decode is ignored.
  - data_read[15:8] <= 0.
  - data_read[7:0] <= {vbase[7:3], iack_level} if active[iack_level] is set; otherwise SPURIOUS_VEC.
  - ack as above.
  - Edge-mode pending[iack_level] is cleared once, on the first strobe cycle of the acknowledge. An internal iack_done flag suppresses the clear until the strobes drop.
  - A new edge arriving during the acknowledge re-sets pending after iack_done.
- iack_level=0: spurious vector, no clear.
- iack with rw=0: ignored, no ack.
- Reset mid-cycle: all state returns to reset values at that edge; ack=0 the next cycle.

Optional Feature:
- Macro: IRQ_AUTOVEC_EN.
- When defined:
  - Adds output avec_n (1 bit, reset 1) and register 5, AVEC (bits 7:1 per level, reset 0).
  - In an IACK cycle for a level whose AVEC bit is set, avec_n <= 0 instead of ack <= 1. data_read is unchanged and the pending clear still occurs.
  - avec_n returns to 1 when the strobes drop.
- When undefined: no avec_n port, word 5 reads 0, and all IACKs are vectored.

Test Plan:
1. Reset -> ipl_n=3'b111, ack=0; read words 0..3 gives 0x0000, 0x0000, 0x00FE, 0x0040.
2. MASK=0x40 (level 6); pulse irq_in[5] for 1 clk -> PENDING reads 0x0040, ipl_n=3'b001 two clks after the pulse.
3. Levels 2 and 6 pending, both masked in -> ipl_n=~6. IACK level 6 returns vector 0x46 with one ack and clears bit 6. ipl_n then becomes ~2.
4. MODE bit 3 = 0 (level mode), irq_in[2] held high -> W1C to bit 3 has no effect and IACK level 3 does not clear it. irq_in low -> pending clears next clk and ipl_n=3'b111.
5. IACK level 4 with nothing pending -> data_read=0x0018 and no state change. Write 0x0010 to PENDING on the same cycle an edge arrives on level 4 -> bit remains set.
6. IRQ_AUTOVEC_EN: AVEC=0x80; IACK level 7 -> avec_n=0, ack stays 0, pending[7] cleared.
